frac_div_mash: RTL and testbench
================================

FRAC_DIV_MASH -- requirements
Module: frac_div_mash

Interface
REQ-001 Parameter INT_W, default 8, sets the integer ratio width.
REQ-002 Parameter FRAC_W, default 16, sets the fraction width; the fractional ratio is f_frac/2^FRAC_W.
REQ-003 Parameter MIN_DIV, default 2, sets the smallest legal effective modulus (must be >= 2).
REQ-004 in_clk  input  1  single clock; the block is clocked only by in_clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 n_int  input  INT_W  integer divide ratio, sampled on config accept.
REQ-007 f_frac  input  FRAC_W  fractional numerator, sampled on config accept.
REQ-008 order  input  2  modulator order: 0 = integer only; 1, 2, 3 = MASH 1, 1-1, 1-1-1. Sampled on config accept.
REQ-009 dither_en  input  1  LSB dither enable, sampled on config accept.
REQ-010 cfg_valid  input  1  a new configuration is present on n_int, f_frac, order and dither_en.
REQ-011 cfg_ready  output  1  the block can accept a configuration.
REQ-012 out_clk  output  1  divided clock, driven from a register.
REQ-013 period_start  output  1  one-cycle pulse on the first in_clk cycle of each output period.
REQ-014 mod_out  output  4  signed modulator output y applied to the current period.
REQ-015 cfg_err  output  1  sticky flag: the effective modulus was clamped.

Function
REQ-016 The block has two states, IDLE and RUN, and one pending configuration buffer.
REQ-017 A configuration is accepted on any cycle with cfg_valid=1 and cfg_ready=1; cfg_ready = !pending.
- IDLE: an accepted configuration loads the active registers directly, clears all accumulators and delay registers, and moves to RUN on the next cycle.
- RUN: an accepted configuration is stored as pending; cfg_ready is low until that configuration is applied.
REQ-018 At each period boundary (down-counter cnt == 0) in RUN, a pending configuration is copied to the active registers and pending is cleared. Accumulators are NOT cleared, so phase stays continuous.
REQ-019 The modulator advances exactly once per output period, on the cycle period_start is asserted, using the active f_frac. Three FRAC_W-bit accumulators wrap modulo 2^FRAC_W and produce carries c1, c2, c3.
REQ-020 The modulator output y depends on order:
- order 0: y = 0
- order 1: y = c1
- order 2: y = c1 + c2 - c2_d
- order 3: y = c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd)
- _d and _dd are values from one and two periods earlier; y ranges from -3 to +4.
REQ-021 When the active dither_en = 1, the accumulator-1 input LSB is XORed with bit 0 of a 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; seed 0xACE1). The LFSR steps once per period.
REQ-022 The effective modulus is N = n_int + y, computed at INT_W+2 bits signed. If N < MIN_DIV, N is set to MIN_DIV and cfg_err is set.
REQ-023 On period_start, cnt loads N-1 and then decrements once per in_clk cycle to 0.
REQ-024 out_clk = 1 while cnt >= floor(N/2), so the output is high for ceil(N/2) cycles and low for floor(N/2) cycles.
REQ-025 The first period_start occurs on the first cycle in RUN. Each subsequent period_start occurs on the cycle after cnt == 0.
REQ-026 mod_out updates on period_start and holds for the whole period.
REQ-027 cfg_err is cleared only by reset or by a configuration accept. If a clamp and an accept occur in the same cycle, the set wins.
REQ-028 Accept and period boundary in the same cycle: the existing pending configuration is applied and the new one becomes pending. No configuration is lost.
REQ-029 Changing order in RUN does not clear the carry delay registers.

Reset
REQ-030 While rst = 1, all outputs and state are forced, asynchronously:
- state = IDLE, pending = 0, active registers = 0
- accumulators and delay registers = 0, LFSR = 0xACE1, cnt = 0
- out_clk = 0, period_start = 0, mod_out = 0, cfg_err = 0, cfg_ready = 1
REQ-031 Reset asserted mid-period aborts immediately. After reset release, the block stays in IDLE until a new configuration is accepted.

Verification
REQ-032 order=0, n_int=3, accept in IDLE -> out_clk repeats high 2 / low 1; mod_out=0; period_start every 3 cycles.
REQ-033 order=1, n_int=4, f_frac=32768 -> period lengths 4,5,4,5,...; mod_out 0,1,0,1.
REQ-034 order=1, n_int=4, f_frac=16384 -> period lengths 4,4,4,5 repeating.
REQ-035 order=3, n_int=8, f_frac=21845, dither off, 3000 periods -> mean period 8.333 +/- 0.01; mod_out always within -3..4; no cfg_err.
REQ-036 order=3, n_int=2 -> a clamped period is exactly 2 cycles and cfg_err=1. A subsequent accept of n_int=10 clears cfg_err and applies at the next boundary.
REQ-037 Second cfg_valid while pending -> cfg_ready=0 until the boundary. Back-to-back configurations are applied in order, one per boundary. rst pulsed mid-period -> out_clk=0 immediately and the block enters IDLE.

Source files
------------

// File: rtl/frac_div_mash.sv
// Fractional-N clock divider: a MASH 1 / 1-1 / 1-1-1 sigma-delta modulator
// dithers the integer modulus so that the average output period is n_int + f_frac/2^FRAC_W.
module frac_div_mash #(
    parameter int INT_W   = 8,
    parameter int FRAC_W  = 16,
    parameter int MIN_DIV = 2
) (
    input  logic              in_clk,
    input  logic              rst,
    input  logic [INT_W-1:0]  n_int,
    input  logic [FRAC_W-1:0] f_frac,
    input  logic [1:0]        order,
    input  logic              dither_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              out_clk,
    output logic              period_start,
    output logic [3:0]        mod_out,
    output logic              cfg_err
);
    localparam int NW = INT_W + 2;
    localparam logic [NW-1:0] MIN_N = NW'(MIN_DIV);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [INT_W-1:0]  act_n, pend_n, src_n;
    logic [FRAC_W-1:0] act_f, pend_f, src_f;
    logic [1:0]        act_ord, pend_ord, src_ord;
    logic              act_dith, pend_dith, src_dith;
    logic              pending;

    logic [FRAC_W-1:0] acc1, acc2, acc3, a1, a2, a3, in1;
    logic              c2_d, c3_d, c3_dd, c2d_s, c3d_s, c3dd_s;
    logic [FRAC_W:0]   sum1, sum2, sum3;
    logic              c1, c2, c3;
    logic [15:0]       lfsr;
    logic [3:0]        y;
    logic [NW-1:0]     cnt, half, n_raw, n_eff, n_m1, cnt_m1;
    logic              accept, boundary, clamp;

    assign cfg_ready = !pending;
    assign accept    = cfg_valid && !pending;
    assign boundary  = (state_q == IDLE) ? accept : (cnt == '0);

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && accept)
            state_d = RUN;
    end

    // The period being started uses the incoming config in IDLE, the pending
    // one if it is due now, otherwise the active one. IDLE starts from zero state.
    always_comb begin
        src_n    = act_n;
        src_f    = act_f;
        src_ord  = act_ord;
        src_dith = act_dith;
        a1 = acc1;
        a2 = acc2;
        a3 = acc3;
        c2d_s  = c2_d;
        c3d_s  = c3_d;
        c3dd_s = c3_dd;
        if (state_q == IDLE) begin
            src_n    = n_int;
            src_f    = f_frac;
            src_ord  = order;
            src_dith = dither_en;
            a1 = '0;
            a2 = '0;
            a3 = '0;
            c2d_s  = 1'b0;
            c3d_s  = 1'b0;
            c3dd_s = 1'b0;
        end else if (pending) begin
            src_n    = pend_n;
            src_f    = pend_f;
            src_ord  = pend_ord;
            src_dith = pend_dith;
        end
    end

    always_comb begin
        in1  = src_f ^ {{(FRAC_W-1){1'b0}}, src_dith & lfsr[0]};
        sum1 = {1'b0, a1} + {1'b0, in1};
        sum2 = {1'b0, a2} + {1'b0, sum1[FRAC_W-1:0]};
        sum3 = {1'b0, a3} + {1'b0, sum2[FRAC_W-1:0]};
        c1 = sum1[FRAC_W];
        c2 = sum2[FRAC_W];
        c3 = sum3[FRAC_W];
        // Two's-complement arithmetic on 4 bits; y stays within -3..+4.
        case (src_ord)
            2'd0: y = 4'd0;
            2'd1: y = {3'b0, c1};
            2'd2: y = {3'b0, c1} + {3'b0, c2} - {3'b0, c2d_s};
            default: y = {3'b0, c1} + {3'b0, c2} - {3'b0, c2d_s}
                       + {3'b0, c3} - {2'b0, c3d_s, 1'b0} + {3'b0, c3dd_s};
        endcase
        n_raw  = {2'b00, src_n} + {{(NW-4){y[3]}}, y};
        clamp  = $signed(n_raw) < $signed(MIN_N);
        n_eff  = clamp ? MIN_N : n_raw;
        n_m1   = n_eff - NW'(1);
        cnt_m1 = cnt - NW'(1);
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            act_n <= '0;  act_f <= '0;  act_ord <= '0;  act_dith <= 1'b0;
            pend_n <= '0; pend_f <= '0; pend_ord <= '0; pend_dith <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (boundary && (state_q == IDLE || pending)) begin
                act_n    <= src_n;
                act_f    <= src_f;
                act_ord  <= src_ord;
                act_dith <= src_dith;
            end
            if (state_q == RUN && accept) begin
                pend_n    <= n_int;
                pend_f    <= f_frac;
                pend_ord  <= order;
                pend_dith <= dither_en;
                pending   <= 1'b1;
            end else if (state_q == RUN && boundary) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            acc1 <= '0; acc2 <= '0; acc3 <= '0;
            c2_d <= 1'b0; c3_d <= 1'b0; c3_dd <= 1'b0;
            lfsr <= 16'hACE1;
            cnt <= '0;
            half <= '0;
            out_clk <= 1'b0;
            period_start <= 1'b0;
            mod_out <= '0;
            cfg_err <= 1'b0;
        end else begin
            period_start <= 1'b0;
            if (boundary) begin
                acc1  <= sum1[FRAC_W-1:0];
                acc2  <= sum2[FRAC_W-1:0];
                acc3  <= sum3[FRAC_W-1:0];
                c2_d  <= c2;
                c3_d  <= c3;
                c3_dd <= c3d_s;
                lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                cnt   <= n_m1;
                half  <= n_eff >> 1;
                out_clk <= (n_m1 >= (n_eff >> 1));
                period_start <= 1'b1;
                mod_out <= y;
            end else if (state_q == RUN) begin
                cnt <= cnt_m1;
                out_clk <= (cnt_m1 >= half);
            end
            if (boundary && clamp)
                cfg_err <= 1'b1;
            else if (accept)
                cfg_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frac_div_mash.sv
// Directed bench for frac_div_mash: table of per-config period/mod_out sequences
// plus hand-written sequences for pending configs, clamping, reset and long-run mean.
module tb_frac_div_mash;
    logic        in_clk = 1'b0;
    logic        rst;
    logic [7:0]  n_int;
    logic [15:0] f_frac;
    logic [1:0]  order;
    logic        dither_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        out_clk;
    logic        period_start;
    logic [3:0]  mod_out;
    logic        cfg_err;

    frac_div_mash #(.INT_W(8), .FRAC_W(16), .MIN_DIV(2)) dut (
        .in_clk(in_clk), .rst(rst), .n_int(n_int), .f_frac(f_frac), .order(order),
        .dither_en(dither_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .out_clk(out_clk), .period_start(period_start), .mod_out(mod_out), .cfg_err(cfg_err)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [7:0]       n;
        logic [15:0]      f;
        logic [1:0]       ord;
        logic [3:0][8:0]  len;
        logic [3:0][3:0]  md;
        logic             err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < 600);
    endtask

    task automatic run_period(output int len, output int hi);
        len = 0;
        hi = 0;
        do begin
            if (out_clk) hi++;
            len++;
            step();
        end while (!period_start && len < 600);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        n_int = '0; f_frac = '0; order = '0; dither_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic accept(input int n, input int f, input int o, input int d);
        n_int = 8'(n);
        f_frac = 16'(f);
        order = 2'(o);
        dither_en = 1'(d);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    function automatic vec_t mk(input int n, input int f, input int o,
                                input int l0, input int l1, input int l2, input int l3,
                                input int m0, input int m1, input int m2, input int m3,
                                input int e);
        vec_t v;
        v.n = 8'(n); v.f = 16'(f); v.ord = 2'(o);
        v.len[0] = 9'(l0); v.len[1] = 9'(l1); v.len[2] = 9'(l2); v.len[3] = 9'(l3);
        v.md[0] = 4'(m0); v.md[1] = 4'(m1); v.md[2] = 4'(m2); v.md[3] = 4'(m3);
        v.err = 1'(e);
        return v;
    endfunction

    task automatic mean_run(input string tag, input int n, input int f, input int o,
                            input int d, input int np);
        int sum, bad, len, hi, exp_sum, tol;
        do_reset();
        accept(n, f, o, d);
        sum = 0;
        bad = 0;
        for (int p = 0; p < np; p++) begin
            if ($signed(mod_out) < -3 || $signed(mod_out) > 4) bad++;
            run_period(len, hi);
            sum += len;
        end
        exp_sum = np * n + (np * f) / 65536;
        tol = np / 100;
        chk({tag, "_range_viol"}, bad, 0);
        n_cmp++;
        if (sum < exp_sum - tol || sum > exp_sum + tol) begin
            n_bad++;
            $display("FAIL %s_mean: got %0d cycles in %0d periods, expected %0d +/- %0d",
                     tag, sum, np, exp_sum, tol);
        end
        chk({tag, "_err"}, cfg_err, 0);
    endtask

    vec_t vt[8];

    initial begin
        int len, hi, n;

        vt[0] = mk(3,   0,     0, 3, 3, 3, 3,     0, 0, 0, 0,  0);
        vt[1] = mk(4,   32768, 1, 4, 5, 4, 5,     0, 1, 0, 1,  0);
        vt[2] = mk(4,   16384, 1, 4, 4, 4, 5,     0, 0, 0, 1,  0);
        vt[3] = mk(5,   32768, 2, 5, 6, 6, 5,     0, 1, 1, 0,  0);
        vt[4] = mk(2,   0,     0, 2, 2, 2, 2,     0, 0, 0, 0,  0);
        vt[5] = mk(6,   32768, 3, 6, 8, 5, 7,     0, 2, -1, 1, 0);
        vt[6] = mk(2,   32768, 3, 2, 4, 2, 3,     0, 2, -1, 1, 1);
        vt[7] = mk(255, 0,     0, 255, 255, 255, 255, 0, 0, 0, 0, 0);

        rst = 1'b1;
        cfg_valid = 1'b0;
        n_int = '0; f_frac = '0; order = '0; dither_en = 1'b0;
        step();
        step();
        chk("rst_out_clk", out_clk, 0);
        chk("rst_period_start", period_start, 0);
        chk("rst_mod_out", mod_out, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cfg_ready", cfg_ready, 1);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            chk($sformatf("v%0d_idle_ps", i), period_start, 0);
            accept(vt[i].n, vt[i].f, vt[i].ord, 0);
            chk($sformatf("v%0d_first_ps", i), period_start, 1);
            for (int p = 0; p < 8; p++) begin
                chk($sformatf("v%0d_p%0d_mod", i, p), mod_out, vt[i].md[p % 4]);
                run_period(len, hi);
                chk($sformatf("v%0d_p%0d_len", i, p), len, vt[i].len[p % 4]);
                chk($sformatf("v%0d_p%0d_high", i, p), hi, (vt[i].len[p % 4] + 1) / 2);
            end
            chk($sformatf("v%0d_err", i), cfg_err, vt[i].err);
        end

        // Clamp, then a new accept clears cfg_err and takes effect at the next boundary.
        do_reset();
        accept(2, 32768, 3, 0);
        run_period(len, hi);
        run_period(len, hi);
        chk("clamp_mod", mod_out, 4'hF);
        chk("clamp_err_set", cfg_err, 1);
        accept(10, 0, 0, 0);
        chk("clamp_err_cleared", cfg_err, 0);
        chk("clamp_ready_low", cfg_ready, 0);
        wait_ps(n);
        chk("clamp_period_len", n, 1);
        chk("new_cfg_ready", cfg_ready, 1);
        run_period(len, hi);
        chk("new_cfg_len", len, 10);
        chk("new_cfg_err", cfg_err, 0);

        // Back-to-back configurations: held cfg_valid only accepted once ready returns.
        do_reset();
        accept(3, 0, 0, 0);
        accept(5, 0, 0, 0);
        chk("b2b_ready_low", cfg_ready, 0);
        n_int = 8'd7;
        cfg_valid = 1'b1;
        step();
        chk("b2b_ready_still_low", cfg_ready, 0);
        step();
        chk("b2b_p2_ps", period_start, 1);
        chk("b2b_ready_back", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("b2b_ready_low2", cfg_ready, 0);
        wait_ps(n);
        chk("b2b_p2_rest", n, 4);
        run_period(len, hi);
        chk("b2b_p3_len", len, 7);
        run_period(len, hi);
        chk("b2b_p4_len", len, 7);

        // Asynchronous reset in the middle of a high phase.
        do_reset();
        accept(8, 0, 0, 0);
        step();
        step();
        chk("mid_out_clk_high", out_clk, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_clk", out_clk, 0);
        chk("async_ps", period_start, 0);
        chk("async_ready", cfg_ready, 1);
        rst = 1'b0;
        hi = 0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_clk) hi++;
            if (period_start) n++;
        end
        chk("idle_after_rst_high", hi, 0);
        chk("idle_after_rst_ps", n, 0);
        accept(3, 0, 0, 0);
        chk("restart_ps", period_start, 1);

        mean_run("mash3", 8, 21845, 3, 0, 3000);
        mean_run("mash3_dith", 8, 21845, 3, 1, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
